// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one en/ack multiplier among NUM_REQ requesters.
// Optional WAIT-state timeout abort is built when MUL_ARB_TIMEOUT_EN is defined.
module mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [2*DW-1:0]       result,
    output logic                  err,
    output logic                  mul_en,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic                  mul_ack,
    input  logic [2*DW-1:0]       mul_out
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] win;
    logic          win_valid;
    logic [IW-1:0] ptr_next;

    // First set request bit searching upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        win       = ptr;
        win_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win       = IW'(idx);
            end
        end
    end

    assign ptr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt    <= '0;
            err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (win_valid) begin
                        owner  <= win;
                        gnt    <= ONE_HOT0 << win;
                        mul_en <= 1'b1;
                        mul_a  <= req_a[int'(win)*DW +: DW];
                        mul_b  <= req_b[int'(win)*DW +: DW];
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    mul_en <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
                    cnt    <= '0;
`endif
                    state  <= StWait;
                end
                StWait: begin
                    if (mul_ack) begin
                        result <= mul_out;
                        done   <= ONE_HOT0 << owner;
                        state  <= StDone;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    // Abort on the TIMEOUT-th WAIT cycle without an ack.
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        result <= '0;
                        done   <= ONE_HOT0 << owner;
                        err    <= 1'b1;
                        state  <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                StDone: begin
                    done  <= '0;
                    gnt   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                    ptr   <= ptr_next;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a behavioural en/ack multiplier.
module tb_mul_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [2*W-1:0]  result;
    logic            err;
    logic            mul_en;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_ack;
    logic [2*W-1:0]  mul_out;
    logic            ack_block;

    int errors = 0;
    int checks = 0;

    mul_arbiter #(.NUM_REQ(NR), .DW(W), .TIMEOUT(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_a   (req_a),
        .req_b   (req_b),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .err     (err),
        .mul_en  (mul_en),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_ack (mul_ack),
        .mul_out (mul_out)
    );

    always #5 clk = ~clk;

    // Multiplier: registered product with ack one cycle after en.
    always @(posedge clk) begin
        if (rst) begin
            mul_ack <= 1'b0;
            mul_out <= '0;
        end else begin
            mul_ack <= mul_en && !ack_block;
            if (mul_en) mul_out <= 16'(mul_a) * 16'(mul_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        ack_block = 1'b0;
        rst       = 1'b1;
        step(2);
        check("rst_gnt",    32'(gnt),    32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_mul_en", 32'(mul_en), 32'd0);
        check("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        rst = 1'b0;

        // Single request: 10 * 2.
        set_ops(0, 8'd10, 8'd2);
        req = 4'b0001;
        step();
        check("single_gnt",    32'(gnt),    32'h1);
        check("single_mul_en", 32'(mul_en), 32'd1);
        check("single_mul_a",  32'(mul_a),  32'd10);
        check("single_mul_b",  32'(mul_b),  32'd2);
        step();
        check("single_en_drop", 32'(mul_en), 32'd0);
        step();
        check("single_done",   32'(done),   32'h1);
        check("single_result", 32'(result), 32'd20);
        check("single_err",    32'(err),    32'd0);
        req = '0;
        step();
        check("single_gnt_clr",  32'(gnt),    32'd0);
        check("single_done_clr", 32'(done),   32'd0);
        check("single_hold",     32'(result), 32'd20);
        check("single_ab_hold",  32'(mul_a),  32'd10);

        // Width: ptr is now 1, so requester 1 wins; 255*255.
        set_ops(1, 8'd255, 8'd255);
        req = 4'b0010;
        step();
        check("width_gnt", 32'(gnt), 32'h2);
        step(2);
        check("width_done",   32'(done),   32'h2);
        check("width_result", 32'(result), 32'hFE01);
        req = '0;
        step();

        // Contention from reset: owners 0..3, grants at cycles 1,5,9,13.
        do_reset();
        for (int i = 0; i < NR; i++) set_ops(i, W'(i + 1), 8'd3);
        req = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            step();
            check($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(1 << k));
            step(2);
            check($sformatf("cont_done%0d", k), 32'(done), 32'(1 << k));
            check($sformatf("cont_res%0d", k), 32'(result), 32'((k + 1) * 3));
            req[k] = 1'b0;
            step();
        end
        step();
        check("cont_idle_gnt", 32'(gnt), 32'd0);

        // Fairness: req0 held, req2 held -> 0,2,0,2.
        do_reset();
        set_ops(0, 8'd4, 8'd5);
        set_ops(2, 8'd6, 8'd7);
        req = 4'b0101;
        for (int r = 0; r < 4; r++) begin
            step();
            check($sformatf("fair_gnt%0d", r), 32'(gnt), (r % 2 == 0) ? 32'h1 : 32'h4);
            step(2);
            check($sformatf("fair_res%0d", r), 32'(result), (r % 2 == 0) ? 32'd20 : 32'd42);
            step();
        end
        req = '0;
        step(2);

        // Reset during WAIT discards the in-flight operation.
        do_reset();
        set_ops(1, 8'd7, 8'd9);
        ack_block = 1'b1;
        req = 4'b0010;
        step();
        check("rmid_gnt", 32'(gnt), 32'h2);
        step(2);
        check("rmid_no_done", 32'(done), 32'd0);
        set_ops(3, 8'd5, 8'd4);
        req       = 4'b1000;
        ack_block = 1'b0;
        rst       = 1'b1;
        step();
        check("rmid_gnt0",    32'(gnt),    32'd0);
        check("rmid_done0",   32'(done),   32'd0);
        check("rmid_result0", 32'(result), 32'd0);
        check("rmid_mul0",    {15'd0, mul_en, mul_a, mul_b}, 32'd0);
        check("rmid_err0",    32'(err),    32'd0);
        rst = 1'b0;
        step();
        check("rmid_gnt3", 32'(gnt), 32'h8);
        step(2);
        check("rmid_done3",   32'(done),   32'h8);
        check("rmid_result3", 32'(result), 32'd20);
        req = '0;
        step();

        // Multiplier never acks.
        do_reset();
        set_ops(0, 8'd3, 8'd3);
        set_ops(1, 8'd2, 8'd8);
        ack_block = 1'b1;
        req = 4'b0001;
        step();
        check("to_gnt", 32'(gnt), 32'h1);
        step(15);
        check("to_no_done_early", 32'(done), 32'd0);
        step();
`ifdef MUL_ARB_TIMEOUT_EN
        check("to_done",   32'(done),   32'h1);
        check("to_err",    32'(err),    32'd1);
        check("to_result", 32'(result), 32'd0);
        req       = 4'b0010;
        ack_block = 1'b0;
        step();
        check("to_err_clr", 32'(err), 32'd0);
        step();
        check("to_ptr_adv", 32'(gnt), 32'h2);
        step(2);
        check("to_next_res", 32'(result), 32'd16);
        req = '0;
        step();
`else
        check("stuck_done", 32'(done), 32'd0);
        check("stuck_err",  32'(err),  32'd0);
        step(10);
        check("stuck_gnt",  32'(gnt),  32'h1);
        check("stuck_done2", 32'(done), 32'd0);
        check("stuck_err2", 32'(err),  32'd0);
        ack_block = 1'b0;
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
